alu_sequencer: RTL

Multi-cycle sequencer for the 16-bit ALU datapath.
- Accepts one operation per start/done handshake and drives the existing ripple adder and barrel shifter.
- Runs 16-iteration shift-and-add multiply and restoring divide on that same adder/shifter hardware.
- Presents a registered 32-bit result plus status flags.
- Sits between instruction decode and the register file, replacing the empty ALU shell.

---
 rtl/alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle sequencer for the 16-bit ALU datapath. Accepts one
//            operation per start/done handshake and drives one shared ripple
//            adder and one logical barrel shifter. Runs ADD/ADC/SUB/SHL/SHR in
//            a single execute cycle. Runs a 16-iteration shift-and-add
//            multiply and a restoring divide on that same adder. Presents a
//            registered 32-bit result plus {E,V,N,Z,C} flags.
// Ports    : clk, reset (async, active-high)
//            start, opcode[3:0], operand1[15:0], operand2[15:0], status_in[3:0]
//            busy, done, result_hi[15:0], result_lo[15:0], status_out[4:0]
// Config   : ALU_SEQ_DIV_EN - builds the DIV state and the restoring-divide
//            logic. When it is undefined, opcode 6 is treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic [3:0]       status_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [4:0]       status_out
);

    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_ADC = 4'd1;
    localparam logic [3:0] c_OP_SUB = 4'd2;
    localparam logic [3:0] c_OP_SHL = 4'd3;
    localparam logic [3:0] c_OP_SHR = 4'd4;
    localparam logic [3:0] c_OP_MUL = 4'd5;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] c_OP_DIV = 4'd6;
`endif
    localparam logic [4:0] c_ITERS  = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_cin;
    logic [WIDTH-1:0]   r_hi;     // MUL upper accumulator / DIV remainder
    logic [WIDTH-1:0]   r_lo;     // MUL multiplier->product low / DIV quotient
    logic [4:0]         r_cnt;
    logic [4:0]         r_flags;

    logic [WIDTH-1:0]   w_add_a;
    logic [WIDTH-1:0]   w_add_b;
    logic               w_add_ci;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf;
    logic [WIDTH:0]     w_shl_ext;
    logic [WIDTH:0]     w_shr_ext;
    logic [WIDTH-1:0]   w_ex_hi;
    logic [WIDTH-1:0]   w_ex_lo;
    logic               w_ex_c;
    logic               w_ex_v;
    logic               w_ex_e;
    logic               w_unused_status;

    // Only the carry bit of the incoming status is consumed.
    assign w_unused_status = ^status_in[3:1];

`ifdef ALU_SEQ_DIV_EN
    // Partial remainder after the left shift is 17 bits wide; its top bit
    // alone guarantees the trial subtraction succeeds.
    logic [WIDTH:0]     w_part;
    logic               w_no_borrow;
    assign w_part      = {r_hi, r_lo[WIDTH-1]};
    assign w_no_borrow = w_part[WIDTH] | w_sum[WIDTH];
`endif

    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (opcode == c_OP_MUL)
                        w_state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    else if (opcode == c_OP_DIV && operand2 != '0)
                        w_state_nxt = S_DIV;
`endif
                    else
                        w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:       w_state_nxt = S_DONE;
            S_MUL, S_DIV: if (r_cnt == c_ITERS) w_state_nxt = S_DONE;
            S_DONE:       w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------- shared ripple adder
    always_comb begin
        w_add_a  = r_opa;
        w_add_b  = r_opb;
        w_add_ci = 1'b0;
        case (r_state)
            S_EXEC: begin
                if (r_op == c_OP_ADC) w_add_ci = r_cin;
                if (r_op == c_OP_SUB) begin
                    w_add_b  = ~r_opb;
                    w_add_ci = 1'b1;
                end
            end
            S_MUL: begin
                w_add_a = r_hi;
                w_add_b = r_lo[0] ? r_opb : '0;
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                w_add_a  = w_part[WIDTH-1:0];
                w_add_b  = ~r_opb;
                w_add_ci = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_add_ci};
    assign w_ovf = (w_add_a[WIDTH-1] == w_add_b[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != w_add_a[WIDTH-1]);

    // Extra guard bit catches the last bit shifted out; it stays 0 for amount 0.
    assign w_shl_ext = {1'b0, r_opa} << r_opb[3:0];
    assign w_shr_ext = {r_opa, 1'b0} >> r_opb[3:0];

    // ------------------------------------------------ single-cycle results
    always_comb begin
        w_ex_hi = '0;
        w_ex_lo = '0;
        w_ex_c  = 1'b0;
        w_ex_v  = 1'b0;
        w_ex_e  = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_ADC: begin
                w_ex_lo = w_sum[WIDTH-1:0];
                w_ex_c  = w_sum[WIDTH];
                w_ex_v  = w_ovf;
            end
            c_OP_SUB: begin
                w_ex_lo = w_sum[WIDTH-1:0];
                w_ex_c  = ~w_sum[WIDTH];    // borrow
                w_ex_v  = w_ovf;
            end
            c_OP_SHL: begin
                w_ex_lo = w_shl_ext[WIDTH-1:0];
                w_ex_c  = w_shl_ext[WIDTH];
            end
            c_OP_SHR: begin
                w_ex_lo = w_shr_ext[WIDTH:1];
                w_ex_c  = w_shr_ext[0];
            end
`ifdef ALU_SEQ_DIV_EN
            c_OP_DIV: begin                 // reaches EXEC only for divisor 0
                w_ex_lo = '1;
                w_ex_hi = r_opa;
                w_ex_e  = 1'b1;
            end
`endif
            default: w_ex_e = 1'b1;
        endcase
    end

    // --------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_cin      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_flags    <= '0;
            done       <= 1'b0;
            result_hi  <= '0;
            result_lo  <= '0;
            status_out <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= opcode;
                        r_opa <= operand1;
                        r_opb <= operand2;
                        r_cin <= status_in[0];
                        r_hi  <= '0;
                        r_lo  <= operand1;
                        r_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    r_hi    <= w_ex_hi;
                    r_lo    <= w_ex_lo;
                    r_flags <= {w_ex_e, w_ex_v, w_ex_lo[WIDTH-1],
                                (w_ex_lo == '0), w_ex_c};
                end
                S_MUL: begin
                    if (r_cnt != c_ITERS) begin
                        // Add-if-LSB, then shift {carry,hi,lo} right by one.
                        r_hi  <= w_sum[WIDTH:1];
                        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                        r_cnt <= r_cnt + 5'd1;
                    end else begin
                        r_flags <= {2'b00, r_hi[WIDTH-1],
                                    ({r_hi, r_lo} == '0), 1'b0};
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    if (r_cnt != c_ITERS) begin
                        r_hi  <= w_no_borrow ? w_sum[WIDTH-1:0] : w_part[WIDTH-1:0];
                        r_lo  <= {r_lo[WIDTH-2:0], w_no_borrow};
                        r_cnt <= r_cnt + 5'd1;
                    end else begin
                        r_flags <= {2'b00, r_lo[WIDTH-1], (r_lo == '0), 1'b0};
                    end
                end
`endif
                S_DONE: begin
                    done       <= 1'b1;
                    result_hi  <= r_hi;
                    result_lo  <= r_lo;
                    status_out <= r_flags;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
